// File: rtl/sha256_arb_pkg.sv
// Shared constants for the SHA-256 core arbiter: FSM state codes, digest masks
// and the supported requester count.
package sha256_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  typedef logic [2:0] arb_state_e;

  localparam arb_state_e IDLE  = 3'd0;
  localparam arb_state_e OWNED = 3'd1;
  localparam arb_state_e ISSUE = 3'd2;
  localparam arb_state_e GUARD = 3'd3;
  localparam arb_state_e WAIT  = 3'd4;
  localparam arb_state_e DONE  = 3'd5;

  // SHA-224 truncates the digest to seven words; word 7 sits in the LSBs.
  localparam logic [255:0] SHA256_MASK = {256{1'b1}};
  localparam logic [255:0] SHA224_MASK = {{224{1'b1}}, 32'h0000_0000};

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational round-robin pick: the first requesting index strictly after
// rr_ptr_i (wrapping) wins; grant is one-hot or zero.
module sha256_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arb.sv
// Shares one sha256_core between NUM_REQ requesters, locking the core to one
// requester for a whole message and returning the masked digest to it.
module sha256_core_arb #(
  parameter int NUM_REQ  = 2,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         zeroize,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_first,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DIGEST_W-1:0]          rsp_digest,
  output logic [NUM_REQ-1:0]           req_err,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner_id,
  output logic                         core_init,
  output logic                         core_next,
  output logic                         core_mode,
  output logic                         core_zeroize,
  output logic [BLOCK_W-1:0]           core_block,
  input  logic                         core_ready,
  input  logic                         core_digest_valid,
  input  logic [DIGEST_W-1:0]          core_digest
);
  import sha256_arb_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic                 mode_q, mode_d;
  logic                 last_q, last_d;
  logic                 first_q, first_d;
  logic [DIGEST_W-1:0]  digest_q, digest_d;

  logic [BLOCK_W-1:0]   blk_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   gnt, owner_oh, sel_oh, err;
  logic [PTR_W-1:0]     gnt_idx, sel;
  logic                 accept, kill;

  function automatic logic [DIGEST_W-1:0] mask_digest(input logic [DIGEST_W-1:0] d,
                                                      input logic              m);
    return m ? (d & DIGEST_W'(SHA256_MASK)) : (d & DIGEST_W'(SHA224_MASK));
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_blk
    assign blk_arr[g] = req_block[g*BLOCK_W +: BLOCK_W];
  end

  // Only first blocks compete; non-first blocks in IDLE are errors, not candidates.
  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i    (req_valid & req_first),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign sel_oh   = NUM_REQ'(1) << sel;
  assign kill     = rst | zeroize;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    block_d  = block_q;
    mode_d   = mode_q;
    last_d   = last_q;
    first_d  = first_q;
    digest_d = digest_q;
    accept   = 1'b0;
    sel      = owner_q;
    err      = '0;
    case (state_q)
      IDLE: begin
        err = req_valid & ~req_first;
        if (core_ready && (|gnt)) begin
          accept = 1'b1;
          sel    = gnt_idx;
        end
      end
      OWNED: begin
        err = req_valid & ~req_first & ~owner_oh;
        if (core_ready && req_valid[owner_q]) accept = 1'b1;
      end
      ISSUE: state_d = GUARD;
      // The core's ready/valid still reflect the previous command here.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (core_ready && core_digest_valid) begin
          if (last_q) begin
            digest_d = mask_digest(core_digest, mode_q);
            state_d  = DONE;
          end else begin
            state_d  = OWNED;
          end
        end
      end
      DONE: begin
        rr_ptr_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      block_d = blk_arr[sel];
      last_d  = req_last[sel];
      first_d = req_first[sel];
      owner_d = sel;
      if (req_first[sel]) mode_d = req_mode[sel];
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_REQ-1);
      owner_q  <= '0;
      block_q  <= '0;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      first_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      block_q  <= block_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      first_q  <= first_d;
      digest_q <= digest_d;
    end
  end

  assign req_ready    = kill ? '0 : (err | (accept ? sel_oh : '0));
  assign req_err      = kill ? '0 : err;
  assign rsp_valid    = (!kill && state_q == DONE) ? owner_oh : '0;
  assign rsp_digest   = digest_q;
  assign busy         = (state_q != IDLE);
  assign owner_id     = owner_q;
  assign core_init    = !kill && (state_q == ISSUE) && first_q;
  assign core_next    = !kill && (state_q == ISSUE) && !first_q;
  assign core_mode    = mode_q;
  assign core_zeroize = zeroize;
  assign core_block   = block_q;

endmodule

// File: tb/tb_sha256_core_arb.sv
// Bench for sha256_core_arb: behavioural SHA-256 core, per-requester digest
// scoreboard, directed arbitration/error/zeroize cases and random messages.
module tb_sha256_core_arb;

  localparam int NR = 2;
  localparam int BW = 512;
  localparam int DW = 256;

  localparam logic [BW-1:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [DW-1:0] ABC_256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [DW-1:0] ABC_224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst, zeroize;
  logic [NR-1:0]    req_valid, req_first, req_last, req_mode;
  logic [NR*BW-1:0] req_block;
  logic [NR-1:0]    req_ready, rsp_valid, req_err;
  logic [DW-1:0]    rsp_digest;
  logic             busy;
  logic [0:0]       owner_id;
  logic             core_init, core_next, core_mode, core_zeroize;
  logic [BW-1:0]    core_block;
  logic             core_ready, core_digest_valid;
  logic [DW-1:0]    core_digest;

  logic          rv [NR];
  logic          rf [NR];
  logic          rl [NR];
  logic          rm [NR];
  logic [BW-1:0] rb [NR];

  int checks, errors, rsp_cnt;
  logic [DW-1:0] expq [NR][$];
  int order_q[$];

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0; req_first = '0; req_last = '0; req_mode = '0; req_block = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rv[i];
      req_first[i] = rf[i];
      req_last[i]  = rl[i];
      req_mode[i]  = rm[i];
      req_block[i*BW +: BW] = rb[i];
    end
  end

  sha256_core_arb #(.NUM_REQ(NR), .BLOCK_W(BW), .DIGEST_W(DW)) dut (
    .clk (clk), .rst (rst), .zeroize (zeroize),
    .req_valid (req_valid), .req_first (req_first), .req_last (req_last),
    .req_mode (req_mode), .req_block (req_block), .req_ready (req_ready),
    .rsp_valid (rsp_valid), .rsp_digest (rsp_digest), .req_err (req_err),
    .busy (busy), .owner_id (owner_id), .core_init (core_init),
    .core_next (core_next), .core_mode (core_mode), .core_zeroize (core_zeroize),
    .core_block (core_block), .core_ready (core_ready),
    .core_digest_valid (core_digest_valid), .core_digest (core_digest));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [DW-1:0] iv(input logic m);
    return m ? 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
             : 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  endfunction

  function automatic logic [DW-1:0] compress(input logic [DW-1:0] hin, input logic [BW-1:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [BW-1:0] m;
    m = blk;
    for (int t = 0; t < 16; t++) begin
      w[t] = m[511:480];
      m = m << 32;
    end
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  // Behavioural core: command seen on one edge, ready drops on the next,
  // digest appears a random number of cycles later.
  logic [DW-1:0] hs;
  int  cnt;
  bit  pend;
  always @(posedge clk) begin
    if (rst || core_zeroize) begin
      core_ready <= 1'b1; core_digest_valid <= 1'b0; core_digest <= '0;
      cnt = 0; pend = 0; hs = '0;
    end else if (core_init || core_next) begin
      hs = compress(core_init ? iv(core_mode) : hs, core_block);
      pend = 1;
    end else if (pend) begin
      pend = 0;
      core_ready <= 1'b0; core_digest_valid <= 1'b0;
      cnt = int'($urandom_range(3, 8));
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_ready <= 1'b1; core_digest_valid <= 1'b1; core_digest <= hs;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_ready !== '0) chk("ready_onehot", DW'($onehot(req_ready)), 1);
    if (rsp_valid !== '0) begin
      chk("rsp_onehot", DW'($onehot(rsp_valid)), 1);
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          rsp_cnt++;
          order_q.push_back(i);
          if (expq[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got rsp_valid[%0d] expected none", i);
          end else begin
            chk($sformatf("rsp_digest%0d", i), rsp_digest, expq[i].pop_front());
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sync(); rst = 1'b1;
    sync(); rst = 1'b0;
  endtask

  // Present one block; returns one step after the accepting edge.
  task automatic send_blk(input int i, input logic [BW-1:0] b, input logic f, input logic l,
                          input logic m, output bit ok);
    rb[i] = b; rf[i] = f; rl[i] = l; rm[i] = m; rv[i] = 1'b1;
    ok = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
      @(posedge clk); #1;
    end
    rv[i] = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: requester %0d got no req_ready expected one", i);
    end
  endtask

  task automatic send_msg(input int i, input int nblk, input logic m, input int gap);
    logic [BW-1:0] bl [4];
    logic [DW-1:0] h;
    bit ok;
    h = iv(m);
    for (int b = 0; b < nblk; b++) begin
      bl[b] = rand_blk();
      h = compress(h, bl[b]);
    end
    expq[i].push_back(m ? h : {h[255:32], 32'h0});
    for (int b = 0; b < nblk; b++) begin
      send_blk(i, bl[b], b == 0, b == nblk - 1, m, ok);
      repeat (gap) sync();
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int c = 0; c < 5000 && rsp_cnt < target; c++) @(posedge clk);
    if (rsp_cnt < target) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_cnt, target);
    end
    sync();
  endtask

  task automatic chk_order(input string name, input int a, input int b);
    chk({name, "_count"}, DW'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk({name, "_first"}, DW'(order_q[0]), DW'(a));
      chk({name, "_second"}, DW'(order_q[1]), DW'(b));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base;
    checks = 0; errors = 0; rsp_cnt = 0;
    zeroize = 1'b0;
    for (int i = 0; i < NR; i++) begin rv[i] = 0; rf[i] = 0; rl[i] = 0; rm[i] = 0; rb[i] = '0; end

    // Reset with a first block offered: nothing may respond.
    rst = 1'b1; rv[0] = 1'b1; rf[0] = 1'b1; rl[0] = 1'b1; rm[0] = 1'b1; rb[0] = ABC_BLK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", DW'(req_ready), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_digest", rsp_digest, 0);
    chk("rst_block", DW'(core_block), 0);
    chk("rst_cmd", DW'({core_init, core_next, rsp_valid, req_err}), 0);
    rv[0] = 1'b0; rst = 1'b0;

    // Known-answer SHA-256 and SHA-224 of "abc".
    sync();
    expq[0].push_back(ABC_256);
    send_blk(0, ABC_BLK, 1, 1, 1, ok);
    chk("abc_init", DW'({core_init, core_next}), 2'b10);
    chk("abc_busy", DW'({busy, owner_id}), 2'b10);
    chk("abc_block", DW'(core_block), DW'(ABC_BLK));
    wait_rsp(1);
    repeat (3) sync();
    chk("digest_hold", rsp_digest, ABC_256);
    expq[0].push_back(ABC_224);
    send_blk(0, ABC_BLK, 1, 1, 0, ok);
    chk("abc224_mode", DW'(core_mode), 0);
    wait_rsp(2);

    // Simultaneous first blocks after reset: req0 then req1, twice.
    do_reset();
    order_q.delete();
    fork
      send_msg(0, 1, 1'($urandom), 0);
      send_msg(1, 1, 1'($urandom), 0);
    join
    wait_rsp(4);
    chk_order("pair1", 0, 1);
    order_q.delete();
    fork
      send_msg(0, 2, 1'($urandom), 0);
      send_msg(1, 1, 1'($urandom), 0);
    join
    wait_rsp(6);
    chk_order("pair2", 0, 1);

    // req0 asks mid-message while req1 holds the lock.
    order_q.delete();
    fork
      send_msg(1, 2, 1, 3);
      begin
        for (int c = 0; c < 200 && !(busy && owner_id == 1'b1); c++) sync();
        chk("lock_owner1", DW'({busy, owner_id}), 2'b11);
        send_msg(0, 1, 0, 0);
      end
    join
    wait_rsp(8);
    chk_order("lock", 1, 0);

    // Non-first block while idle: ready+err pulse, dropped.
    repeat (2) sync();
    rv[0] = 1'b1; rf[0] = 1'b0; rl[0] = 1'b1; rb[0] = rand_blk();
    @(negedge clk);
    chk("idle_err", DW'({req_ready, req_err}), 4'b0101);
    chk("idle_err_busy", DW'(busy), 0);
    @(posedge clk); #1; rv[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_err_quiet", DW'({core_init, core_next, busy, req_err}), 0);
    end

    // Zeroize while waiting for the core.
    sync();
    base = rsp_cnt;
    send_blk(0, rand_blk(), 1, 1, 1, ok);
    sync(); sync();
    chk("zero_pre_busy", DW'(busy), 1);
    zeroize = 1'b1;
    @(negedge clk);
    chk("zero_during", DW'({core_zeroize, rsp_valid, req_ready, core_init, core_next}), 7'b1000000);
    @(posedge clk); #1; zeroize = 1'b0;
    chk("zero_busy", DW'(busy), 0);
    chk("zero_digest", rsp_digest, 0);
    chk("zero_block", DW'(core_block), 0);
    repeat (15) sync();
    chk("zero_no_rsp", DW'(rsp_cnt), DW'(base));

    // Random concurrent traffic.
    base = rsp_cnt;
    fork
      for (int n = 0; n < 8; n++) begin
        send_msg(0, int'($urandom_range(1, 3)), 1'($urandom), int'($urandom_range(0, 2)));
        repeat ($urandom_range(0, 5)) sync();
      end
      for (int n = 0; n < 8; n++) begin
        send_msg(1, int'($urandom_range(1, 3)), 1'($urandom), int'($urandom_range(0, 2)));
        repeat ($urandom_range(0, 5)) sync();
      end
    join
    wait_rsp(base + 16);
    chk("sb_empty0", DW'(expq[0].size()), 0);
    chk("sb_empty1", DW'(expq[1].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
